// File: rtl/wbwide_memslave_if.sv
// Pipelined Wishbone request/response bundle for the wide memory slave.
// Master drives the i_* request signals; slave drives the o_* responses.
interface wbwide_memslave_if #(
    parameter int DW = 512,
    parameter int AW = 24
);
    // A request transfers on any cycle with i_wb_cyc && i_wb_stb && !o_wb_stall;
    // each accepted request returns exactly one o_wb_ack or o_wb_err, in order.
    logic              i_wb_cyc;
    logic              i_wb_stb;
    logic              i_wb_we;
    logic [AW-1:0]     i_wb_addr;
    logic [DW-1:0]     i_wb_data;
    logic [DW/8-1:0]   i_wb_sel;
    logic              o_wb_stall;
    logic              o_wb_ack;
    logic              o_wb_err;
    logic [DW-1:0]     o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );
endinterface

// File: rtl/wbwide_memslave.sv
// Wide pipelined Wishbone memory slave: single-port byte-enabled RAM with a
// fixed accept-to-response latency and a bounded number of outstanding requests.
module wbwide_memslave #(
    parameter int DW      = 512,
    parameter int AW      = 24,
    parameter int LGMEMSZ = 10,
    parameter int LATENCY = 2,
    parameter int MAXPEND = 4
) (
    input logic              i_clk,
    input logic              i_reset,
    wbwide_memslave_if.slave wb
);
    localparam int NB   = DW / 8;
    localparam int MEMD = 1 << LGMEMSZ;

    logic [LGMEMSZ-1:0] idx;
    logic               oor;
    logic               stall;
    logic               accept;
    logic               retire;
    logic [2:0]         pending;

    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_err;
    logic [LATENCY-1:0] pipe_we;
    logic [DW-1:0]      pipe_data [LATENCY];
    logic [DW-1:0]      mem [MEMD];

    assign idx    = wb.i_wb_addr[LGMEMSZ-1:0];
    assign oor    = |(wb.i_wb_addr >> LGMEMSZ);
    assign retire = pipe_valid[LATENCY-1];
    // A retiring response frees a slot in the same cycle, so a full pipe keeps streaming.
    assign stall  = (pending == 3'(MAXPEND)) && !retire;
    assign accept = wb.i_wb_cyc && wb.i_wb_stb && !stall;

    assign wb.o_wb_stall = stall;
    assign wb.o_wb_ack   = retire && !pipe_err[LATENCY-1];
    assign wb.o_wb_err   = retire && pipe_err[LATENCY-1];
    assign wb.o_wb_data  = (retire && !pipe_err[LATENCY-1] && !pipe_we[LATENCY-1])
                           ? pipe_data[LATENCY-1] : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pending    <= '0;
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_we    <= '0;
        end else if (!wb.i_wb_cyc) begin
            // Abandoned cycle: drop everything in flight, committed writes stay.
            pending    <= '0;
            pipe_valid <= '0;
        end else begin
            pending       <= pending + 3'(accept) - 3'(retire);
            pipe_valid[0] <= accept;
            pipe_err[0]   <= oor;
            pipe_we[0]    <= wb.i_wb_we;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_we[i]    <= pipe_we[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept && wb.i_wb_we && !oor && !i_reset) begin
            for (int b = 0; b < NB; b++) begin
                if (wb.i_wb_sel[b]) mem[idx][8*b +: 8] <= wb.i_wb_data[8*b +: 8];
            end
        end
    end

    // Read data is captured at acceptance; the output mux hides it unless it is a read ack.
    always_ff @(posedge i_clk) begin
        pipe_data[0] <= mem[idx];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end
endmodule

// File: tb/tb_wbwide_memslave.sv
// Directed bench for wbwide_memslave: two instances (LATENCY=2/MAXPEND=4 and
// LATENCY=4/MAXPEND=2) checked every cycle against a queue-based response model.
module tb_wbwide_memslave;
    localparam int DW  = 512;
    localparam int AW  = 24;
    localparam int LGM = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            cyc   = 1'b0;
    logic            stb   = 1'b0;
    logic            we    = 1'b0;
    logic [AW-1:0]   addr  = '0;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] sel   = '0;
    logic            use_b = 1'b0;

    wbwide_memslave_if #(.DW(DW), .AW(AW)) if_a ();
    wbwide_memslave_if #(.DW(DW), .AW(AW)) if_b ();

    assign if_a.i_wb_cyc  = cyc && !use_b;
    assign if_a.i_wb_stb  = stb && !use_b;
    assign if_a.i_wb_we   = we;
    assign if_a.i_wb_addr = addr;
    assign if_a.i_wb_data = wdata;
    assign if_a.i_wb_sel  = sel;
    assign if_b.i_wb_cyc  = cyc && use_b;
    assign if_b.i_wb_stb  = stb && use_b;
    assign if_b.i_wb_we   = we;
    assign if_b.i_wb_addr = addr;
    assign if_b.i_wb_data = wdata;
    assign if_b.i_wb_sel  = sel;

    wbwide_memslave #(.DW(DW), .AW(AW), .LGMEMSZ(LGM), .LATENCY(2), .MAXPEND(4)) dut_a (
        .i_clk(clk), .i_reset(rst), .wb(if_a)
    );
    wbwide_memslave #(.DW(DW), .AW(AW), .LGMEMSZ(LGM), .LATENCY(4), .MAXPEND(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .wb(if_b)
    );

    logic          obs_ack, obs_err, obs_stall;
    logic [DW-1:0] obs_data;
    assign obs_ack   = use_b ? if_b.o_wb_ack   : if_a.o_wb_ack;
    assign obs_err   = use_b ? if_b.o_wb_err   : if_a.o_wb_err;
    assign obs_stall = use_b ? if_b.o_wb_stall : if_a.o_wb_stall;
    assign obs_data  = use_b ? if_b.o_wb_data  : if_a.o_wb_data;

    // Scoreboard: one entry per accepted request, due cycle and response kind alongside.
    logic [DW-1:0] exp_q[$];
    int            due_q[$];
    bit            err_q[$];
    bit            rd_q[$];
    logic [DW-1:0] mdl_mem [2][1024];

    int            cyc_n    = 0;
    int            checks   = 0;
    int            failures = 0;
    int            ack_cnt  = 0;
    int            err_cnt  = 0;
    int            stall_cnt = 0;
    bit            acc      = 1'b0;
    logic [DW-1:0] last_rd  = '0;
    logic [DW-1:0] pat_a;

    function automatic logic [DW-1:0] pat(int i);
        return {16{32'hC0DE_0000 | 32'(i)}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic flush();
        exp_q.delete();
        due_q.delete();
        err_q.delete();
        rd_q.delete();
    endtask

    // One clock: compare outputs at the negedge, then apply the request at the posedge.
    task automatic tick();
        bit            due_now;
        bit            exp_ack, exp_err, exp_stall, is_oor;
        logic [DW-1:0] exp_data;
        int            lat, maxp, m;
        logic [LGM-1:0] ix;
        lat  = use_b ? 4 : 2;
        maxp = use_b ? 2 : 4;
        m    = use_b ? 1 : 0;
        @(negedge clk);
        due_now   = (due_q.size() > 0) && (due_q[0] == cyc_n);
        exp_ack   = due_now && !err_q[0];
        exp_err   = due_now && err_q[0];
        exp_data  = (exp_ack && rd_q[0]) ? exp_q[0] : '0;
        exp_stall = (due_q.size() == maxp) && !due_now;
        check("ack",   DW'(obs_ack),   DW'(exp_ack));
        check("err",   DW'(obs_err),   DW'(exp_err));
        check("stall", DW'(obs_stall), DW'(exp_stall));
        check("rdata", obs_data, exp_data);
        if (obs_ack) ack_cnt++;
        if (obs_err) err_cnt++;
        if (obs_stall && cyc && stb) stall_cnt++;
        if (exp_ack && rd_q[0]) last_rd = obs_data;
        if (due_now) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            void'(err_q.pop_front());
            void'(rd_q.pop_front());
        end
        acc = cyc && stb && !exp_stall;
        @(posedge clk);
        if (acc) begin
            is_oor = |(addr >> LGM);
            ix     = addr[LGM-1:0];
            due_q.push_back(cyc_n + lat);
            err_q.push_back(is_oor);
            rd_q.push_back(!we && !is_oor);
            exp_q.push_back((!we && !is_oor) ? mdl_mem[m][ix] : '0);
            if (we && !is_oor) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (sel[b]) mdl_mem[m][ix][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        if (!cyc) flush();
        cyc_n++;
        #1;
    endtask

    task automatic req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s);
        int n;
        n = 0;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        do begin
            tick();
            n++;
        end while (!acc && n < 20);
        check("accept", DW'(acc), DW'(1));
        stb = 1'b0;
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        repeat (n) tick();
    endtask

    task automatic end_cycle();
        idle(6);
        cyc = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_ack",   DW'(obs_ack),   '0);
        check("rst_err",   DW'(obs_err),   '0);
        check("rst_stall", DW'(obs_stall), '0);
        check("rst_data",  obs_data,       '0);
        flush();
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        cyc_n++;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        // Full write then immediate read-back of the same word.
        pat_a = {16{32'h1234_56A5}};
        req(1'b1, 24'd5, pat_a, '1);
        req(1'b0, 24'd5, '0, '0);
        end_cycle();
        check("rd_word5", last_rd, pat_a);

        // Byte-masked write: only byte 0 may change.
        req(1'b1, 24'd3, '0, '1);
        req(1'b1, 24'd3, {{63{8'hFF}}, 8'h3C}, 64'h1);
        req(1'b0, 24'd3, '0, '0);
        end_cycle();
        check("rd_word3_byte0", last_rd, DW'(8'h3C));

        // Out-of-range read and write respond with err and leave memory alone.
        err_cnt = 0;
        req(1'b0, 24'h400, '0, '0);
        req(1'b1, 24'h405, {16{32'hDEAD_BEEF}}, '1);
        req(1'b0, 24'd5, '0, '0);
        end_cycle();
        check("err_count", DW'(err_cnt), DW'(2));
        check("word5_unchanged", last_rd, pat_a);

        // Eight back-to-back reads stream with no stall.
        for (int i = 0; i < 8; i++) req(1'b1, AW'(i), pat(i), '1);
        end_cycle();
        stall_cnt = 0;
        ack_cnt   = 0;
        for (int i = 0; i < 8; i++) req(1'b0, AW'(i), '0, '0);
        end_cycle();
        check("burst8_stalls", DW'(stall_cnt), DW'(0));
        check("burst8_acks",   DW'(ack_cnt),   DW'(8));
        check("burst8_last",   last_rd,        pat(7));

        // LATENCY=4, MAXPEND=2 instance: stalls for two cycles per four-request burst.
        use_b = 1'b1;
        stall_cnt = 0;
        ack_cnt   = 0;
        for (int i = 0; i < 4; i++) req(1'b1, AW'(i), pat(i), '1);
        end_cycle();
        check("b_wr_stalls", DW'(stall_cnt), DW'(2));
        check("b_wr_acks",   DW'(ack_cnt),   DW'(4));
        stall_cnt = 0;
        ack_cnt   = 0;
        for (int i = 0; i < 4; i++) req(1'b0, AW'(i), '0, '0);
        end_cycle();
        check("b_rd_stalls", DW'(stall_cnt), DW'(2));
        check("b_rd_acks",   DW'(ack_cnt),   DW'(4));
        check("b_rd_last",   last_rd,        pat(3));

        // Abandoned cycle and mid-burst reset on both instances.
        for (int d = 0; d < 2; d++) begin
            use_b = d[0];
            req(1'b0, 24'd1, '0, '0);
            req(1'b0, 24'd2, '0, '0);
            cyc = 1'b0;
            tick();
            ack_cnt = 0;
            err_cnt = 0;
            idle(5);
            check("drop_no_ack", DW'(ack_cnt), DW'(0));
            check("drop_no_err", DW'(err_cnt), DW'(0));
            stall_cnt = 0;
            ack_cnt   = 0;
            req(1'b0, 24'd2, '0, '0);
            req(1'b0, 24'd3, '0, '0);
            end_cycle();
            check("drop_next_stalls", DW'(stall_cnt), DW'(0));
            check("drop_next_acks",   DW'(ack_cnt),   DW'(2));
            check("drop_next_data",   last_rd,        pat(3));

            req(1'b0, 24'd1, '0, '0);
            req(1'b0, 24'd2, '0, '0);
            do_reset();
            ack_cnt = 0;
            cyc = 1'b1;
            idle(5);
            check("rst_no_ack", DW'(ack_cnt), DW'(0));
            stall_cnt = 0;
            ack_cnt   = 0;
            req(1'b0, 24'd2, '0, '0);
            req(1'b0, 24'd1, '0, '0);
            end_cycle();
            check("rst_next_stalls", DW'(stall_cnt), DW'(0));
            check("rst_next_acks",   DW'(ack_cnt),   DW'(2));
            check("rst_next_data",   last_rd,        pat(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
